// File: rtl/tile_motion_grader.sv
// Per-tile luma motion grader: tile sums, frame-to-frame delta grading, persistence debounce, result FIFO.
// Optional frame summary (sum_valid/sum_count) is built only when MOTION_FRAME_SUMMARY_EN is defined.
module tile_motion_grader #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int GX         = 16,
  parameter int GY         = 16,
  parameter int ACC_W      = 32,
  parameter int LVL_BITS   = 2,
  parameter int PERSIST    = 2,
  parameter int FIFO_DEPTH = 16,
  localparam int TIDX_W    = $clog2(GX * GY)
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [23:0]         s_pData,
  input  logic                s_pVDE,
  input  logic                s_pVSync,
  input  logic [ACC_W-1:0]    thr,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [TIDX_W-1:0]   m_tile,
  output logic [LVL_BITS-1:0] m_level,
  output logic                m_flag,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic                sum_valid,
  output logic [TIDX_W:0]     sum_count
);
  localparam int TW   = H_ACTIVE / GX;
  localparam int TH   = V_ACTIVE / GY;
  localparam int NT   = GX * GY;
  localparam int XW   = (TW > 1) ? $clog2(TW) : 1;
  localparam int YW   = (TH > 1) ? $clog2(TH) : 1;
  localparam int TXW  = (GX > 1) ? $clog2(GX) : 1;
  localparam int TYW  = (GY > 1) ? $clog2(GY) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NLVL = (1 << LVL_BITS) - 1;
  localparam int EW   = TIDX_W + LVL_BITS + 1;

  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_FIRST     = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  // Thresholds double per level and saturate at all-ones instead of wrapping.
  function automatic logic [LVL_BITS-1:0] grade_f(input logic [ACC_W-1:0] d, input logic [ACC_W-1:0] t);
    logic [LVL_BITS-1:0] lvl;
    logic [ACC_W-1:0]    th;
    lvl = '0;
    th  = t;
    for (int k = 1; k <= NLVL; k++) begin
      if (d > th) lvl = lvl + LVL_BITS'(1);
      th = th[ACC_W-1] ? '1 : {th[ACC_W-2:0], 1'b0};
    end
    return lvl;
  endfunction

  logic [1:0]        state_q, state_d;
  logic              vsync_q, vde_q, frame_done_q;
  logic [XW-1:0]     xin_q;
  logic [YW-1:0]     yin_q;
  logic [TXW-1:0]    tx_q;
  logic [TYW-1:0]    ty_q;
  logic [ACC_W-1:0]  acc_q [GX];
  logic [15:0]       luma_full_s;
  logic [7:0]        luma_s;
  logic              vsync_rise_s, vde_fall_s, pix_en_s, last_px_s, last_ln_s, eot_s;
  logic [TIDX_W-1:0] tile_idx_s;
  logic [ACC_W-1:0]  acc_sum_s;

  assign luma_full_s  = 16'd77 * {8'd0, s_pData[23:16]} + 16'd150 * {8'd0, s_pData[15:8]}
                      + 16'd29 * {8'd0, s_pData[7:0]};
  assign luma_s       = 8'(luma_full_s >> 8);
  assign vsync_rise_s = s_pVSync & ~vsync_q;
  assign vde_fall_s   = vde_q & ~s_pVDE;
  assign pix_en_s     = s_pVDE && (state_q != ST_WAIT_SYNC);
  assign last_px_s    = (xin_q == XW'(TW - 1));
  assign last_ln_s    = (yin_q == YW'(TH - 1));
  assign eot_s        = pix_en_s && last_px_s && last_ln_s;
  assign tile_idx_s   = TIDX_W'(ty_q) * TIDX_W'(GX) + TIDX_W'(tx_q);
  assign acc_sum_s    = acc_q[tx_q] + ACC_W'(luma_s);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SYNC: if (vsync_rise_s) state_d = ST_FIRST; else state_d = ST_WAIT_SYNC;
      ST_FIRST:     if (vde_fall_s && frame_done_q) state_d = ST_RUN; else state_d = ST_FIRST;
      ST_RUN:       state_d = ST_RUN;
      default:      state_d = ST_WAIT_SYNC;
    endcase
  end

  // Raster position and per-column tile accumulators; only one tile row is open at a time.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_WAIT_SYNC;
      vsync_q <= 1'b0;
      vde_q <= 1'b0;
      frame_done_q <= 1'b0;
      xin_q <= '0; yin_q <= '0; tx_q <= '0; ty_q <= '0;
      for (int i = 0; i < GX; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= s_pVSync;
      vde_q <= s_pVDE;
      if (vsync_rise_s) begin
        frame_done_q <= 1'b0;
        xin_q <= '0; yin_q <= '0; tx_q <= '0; ty_q <= '0;
        for (int i = 0; i < GX; i++) acc_q[i] <= '0;
      end else if (pix_en_s) begin
        acc_q[tx_q] <= eot_s ? '0 : acc_sum_s;
        if (!last_px_s) xin_q <= xin_q + XW'(1);
        else begin
          xin_q <= '0;
          if (tx_q != TXW'(GX - 1)) tx_q <= tx_q + TXW'(1);
          else begin
            tx_q <= '0;
            if (!last_ln_s) yin_q <= yin_q + YW'(1);
            else begin
              yin_q <= '0;
              if (ty_q != TYW'(GY - 1)) ty_q <= ty_q + TYW'(1);
              else begin
                ty_q <= '0;
                frame_done_q <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  logic              p1_v_q, p1_first_q, p2_v_q, p2_first_q, p3_v_q;
  logic [ACC_W-1:0]  p1_sum_q, p2_diff_q, prev_s, diff_s;
  logic [TIDX_W-1:0] p1_tile_q, p2_tile_q;
  logic [ACC_W-1:0]  prev_q [NT];
  logic [NT-1:0]     flag_q;
  logic [3:0]        pcnt_q [NT];
  logic [LVL_BITS-1:0] level_s;
  logic              flag_old_s, flag_new_s;
  logic [3:0]        cnt_old_s, cnt_new_s;
  logic [EW-1:0]     p3_entry_q;

  assign prev_s = prev_q[p1_tile_q];
  assign diff_s = (p1_sum_q >= prev_s) ? (p1_sum_q - prev_s) : (prev_s - p1_sum_q);

  always_comb begin
    level_s    = p2_first_q ? '0 : grade_f(p2_diff_q, thr);
    flag_old_s = flag_q[p2_tile_q];
    cnt_old_s  = pcnt_q[p2_tile_q];
    if ((level_s != '0) != flag_old_s) begin
      if (cnt_old_s + 4'd1 == 4'(PERSIST)) begin
        flag_new_s = ~flag_old_s;
        cnt_new_s  = 4'd0;
      end else begin
        flag_new_s = flag_old_s;
        cnt_new_s  = cnt_old_s + 4'd1;
      end
    end else begin
      flag_new_s = flag_old_s;
      cnt_new_s  = 4'd0;
    end
  end

  // Three-stage result pipeline: capture sum, difference against previous frame, grade and debounce.
  always_ff @(posedge pclk) begin
    if (rst) begin
      p1_v_q <= 1'b0; p1_first_q <= 1'b0; p1_sum_q <= '0; p1_tile_q <= '0;
      p2_v_q <= 1'b0; p2_first_q <= 1'b0; p2_diff_q <= '0; p2_tile_q <= '0;
      p3_v_q <= 1'b0; p3_entry_q <= '0;
      flag_q <= '0;
      for (int i = 0; i < NT; i++) begin
        prev_q[i] <= '0;
        pcnt_q[i] <= 4'd0;
      end
    end else begin
      p1_v_q <= eot_s;
      p1_first_q <= (state_q == ST_FIRST);
      p1_sum_q <= acc_sum_s;
      p1_tile_q <= tile_idx_s;
      p2_v_q <= p1_v_q;
      p2_first_q <= p1_first_q;
      p2_diff_q <= diff_s;
      p2_tile_q <= p1_tile_q;
      if (p1_v_q) prev_q[p1_tile_q] <= p1_sum_q;
      p3_v_q <= p2_v_q;
      p3_entry_q <= {p2_tile_q, level_s, flag_new_s};
      if (p2_v_q) begin
        flag_q[p2_tile_q] <= flag_new_s;
        pcnt_q[p2_tile_q] <= cnt_new_s;
      end
    end
  end

  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fcnt_q;
  logic          ovf_q, full_s, pop_s, wr_en_s, drop_s;

  assign m_valid = (fcnt_q != '0);
  assign full_s  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop_s   = m_valid && m_ready;
  assign wr_en_s = p3_v_q && (!full_s || pop_s);
  assign drop_s  = p3_v_q && full_s && !pop_s;
  assign {m_tile, m_level, m_flag} = fifo_q[rd_ptr_q];
  assign ovf     = ovf_q;

  // A full FIFO still accepts a push when the same cycle pops; otherwise the entry is lost and ovf latches.
  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; fcnt_q <= '0; ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (wr_en_s) begin
        fifo_q[wr_ptr_q] <= p3_entry_q;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      fcnt_q <= fcnt_q + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
      if (drop_s) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

`ifdef MOTION_FRAME_SUMMARY_EN
  logic [TIDX_W:0] fc_q, sum_count_q;
  logic            sum_valid_q;
  assign sum_valid = sum_valid_q;
  assign sum_count = sum_count_q;

  // Counts flagged entries whether pushed or dropped; the last tile of a frame closes the tally.
  always_ff @(posedge pclk) begin
    if (rst) begin
      fc_q <= '0; sum_count_q <= '0; sum_valid_q <= 1'b0;
    end else if (p3_v_q && (p3_entry_q[EW-1 -: TIDX_W] == TIDX_W'(NT - 1))) begin
      sum_valid_q <= 1'b1;
      sum_count_q <= fc_q + (TIDX_W+1)'(p3_entry_q[0]);
      fc_q <= '0;
    end else begin
      sum_valid_q <= 1'b0;
      if (p3_v_q && p3_entry_q[0]) fc_q <= fc_q + (TIDX_W+1)'(1);
    end
  end
`else
  assign sum_valid = 1'b0;
  assign sum_count = '0;
`endif

endmodule
